control_responder: RTL and testbench

- Far end of the 2-bit command interface driven by the Moore control FSM.
- Decodes the command pair {inputB1,inputB0} and runs a loadable down-counter.
- Returns the request line outputI and the status line outputS to the controller.
- Sits between the control FSM and the external start/length source; all outputs are Moore (functions of registered state only).

---
 rtl/control_responder_if.sv | 37 +++
 rtl/control_responder.sv | 123 ++++++++++++
 tb/tb_control_responder.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/control_responder_if.sv
// Command/status bundle between the control FSM (master) and the
// responder (slave): two command bits, start/length from the external
// source, and the request/status/count/abort lines back to the controller.
interface control_responder_if #(
    parameter int WIDTH = 4
);
    logic             inputB0;
    logic             inputB1;
    logic             inputStart;
    logic [WIDTH-1:0] inputLen;
    logic             outputI;
    logic             outputS;
    logic [WIDTH-1:0] outputCount;
    logic             outputAbort;

    modport master (
        output inputB0,
        output inputB1,
        output inputStart,
        output inputLen,
        input  outputI,
        input  outputS,
        input  outputCount,
        input  outputAbort
    );

    modport slave (
        input  inputB0,
        input  inputB1,
        input  inputStart,
        input  inputLen,
        output outputI,
        output outputS,
        output outputCount,
        output outputAbort
    );
endinterface

// File: rtl/control_responder.sv
// Far end of the 2-bit command link: decodes {B1,B0} as HOLD/LOAD/RUN/CLEAR,
// runs a loadable down-counter and reports ARMED/DONE back to the
// controller. Every output comes straight from a flop (Moore style).
module control_responder #(
    parameter int WIDTH = 4
) (
    input  logic              inputClk,
    input  logic              inputReset,
    control_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_RUN   = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    logic [1:0]       cmd;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             abort_q, abort_d;
    logic             req_q;
    logic             stat_q;

    assign cmd = {bus.inputB1, bus.inputB0};

    // Next-state decode: command handling per state, counter load/decrement
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Commands are ignored here, so start beats a concurrent CLEAR.
                if (bus.inputStart) begin
                    len_d   = bus.inputLen;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                case (cmd)
                    CMD_LOAD: begin
                        count_d = len_q;
                        state_d = (len_q == '0) ? DONE : RUN;
                    end
                    CMD_CLEAR: begin
                        count_d = '0;
                        abort_d = 1'b1;
                        state_d = IDLE;
                    end
                    CMD_HOLD, CMD_RUN: begin
                    end
                endcase
            end
            RUN: begin
                case (cmd)
                    CMD_HOLD: begin
                    end
                    CMD_LOAD: begin
                        count_d = len_q;
                        if (len_q == '0) state_d = DONE;
                    end
                    CMD_RUN: begin
                        // RUN is never entered with a zero count, so this
                        // decrement cannot wrap.
                        if (count_q == WIDTH'(1)) begin
                            count_d = '0;
                            state_d = DONE;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                    CMD_CLEAR: begin
                        count_d = '0;
                        abort_d = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            DONE: begin
                count_d = '0;
                // CLEAR here is the normal acknowledge, not an abort.
                if (cmd == CMD_CLEAR) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset dominates every input
    always_ff @(posedge inputClk) begin
        if (inputReset) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            abort_q <= 1'b0;
            req_q   <= 1'b0;
            stat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            abort_q <= abort_d;
            req_q   <= (state_d == ARMED);
            stat_q  <= (state_d == DONE);
        end
    end

    assign bus.outputI     = req_q;
    assign bus.outputS     = stat_q;
    assign bus.outputCount = count_q;
    assign bus.outputAbort = abort_q;

endmodule

// File: tb/tb_control_responder.sv
// Directed bench for control_responder: each step pushes the expected
// outputs to a scoreboard queue, clocks the DUT, then pops and compares.
module tb_control_responder;

    localparam int WIDTH = 4;

    localparam logic [1:0] HOLD  = 2'b00;
    localparam logic [1:0] LOAD  = 2'b01;
    localparam logic [1:0] RUN   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    typedef struct {
        string            tag;
        logic             i;
        logic             s;
        logic             ab;
        logic [WIDTH-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb[$];

    control_responder_if #(.WIDTH(WIDTH)) bus ();

    control_responder #(.WIDTH(WIDTH)) dut (
        .inputClk   (clk),
        .inputReset (rst),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, clock it, then check the outputs seen #1 later.
    task automatic cyc(input string tag, input logic r, input logic [1:0] cmd,
                       input logic st, input logic [WIDTH-1:0] len,
                       input logic ei, input logic es, input logic eab,
                       input logic [WIDTH-1:0] ecnt);
        exp_t e;
        e.tag = tag; e.i = ei; e.s = es; e.ab = eab; e.cnt = ecnt;
        sb.push_back(e);
        rst            = r;
        bus.inputB1    = cmd[1];
        bus.inputB0    = cmd[0];
        bus.inputStart = st;
        bus.inputLen   = len;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (bus.outputI === e.i) else begin
            errors++;
            $error("FAIL %s outputI got %0b expected %0b", e.tag, bus.outputI, e.i);
        end
        checks++;
        assert (bus.outputS === e.s) else begin
            errors++;
            $error("FAIL %s outputS got %0b expected %0b", e.tag, bus.outputS, e.s);
        end
        checks++;
        assert (bus.outputAbort === e.ab) else begin
            errors++;
            $error("FAIL %s outputAbort got %0b expected %0b", e.tag, bus.outputAbort, e.ab);
        end
        checks++;
        assert (bus.outputCount === e.cnt) else begin
            errors++;
            $error("FAIL %s outputCount got %0d expected %0d", e.tag, bus.outputCount, e.cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.inputB0 = 1'b0; bus.inputB1 = 1'b0;
        bus.inputStart = 1'b0; bus.inputLen = '0;

        // Reset then idle
        cyc("rst0", 1, HOLD, 0, 4'd0, 0, 0, 0, 4'd0);
        cyc("rst1", 1, HOLD, 0, 4'd0, 0, 0, 0, 4'd0);
        for (int k = 0; k < 5; k++)
            cyc("idle", 0, HOLD, 0, 4'd6, 0, 0, 0, 4'd0);

        // Normal run of length 3
        cyc("n_start", 0, HOLD, 1, 4'd3, 1, 0, 0, 4'd0);
        cyc("n_load",  0, LOAD, 0, 4'd3, 0, 0, 0, 4'd3);
        cyc("n_run1",  0, RUN,  0, 4'd3, 0, 0, 0, 4'd2);
        cyc("n_run2",  0, RUN,  0, 4'd3, 0, 0, 0, 4'd1);
        cyc("n_run3",  0, RUN,  0, 4'd3, 0, 1, 0, 4'd0);
        cyc("n_ack",   0, CLEAR,0, 4'd3, 0, 0, 0, 4'd0);
        cyc("n_after", 0, HOLD, 0, 4'd3, 0, 0, 0, 4'd0);

        // Pause and reload, length 5
        cyc("p_start", 0, HOLD, 1, 4'd5, 1, 0, 0, 4'd0);
        cyc("p_load",  0, LOAD, 0, 4'd5, 0, 0, 0, 4'd5);
        cyc("p_run1",  0, RUN,  0, 4'd5, 0, 0, 0, 4'd4);
        cyc("p_run2",  0, RUN,  0, 4'd5, 0, 0, 0, 4'd3);
        for (int k = 0; k < 4; k++)
            cyc("p_hold", 0, HOLD, 0, 4'd5, 0, 0, 0, 4'd3);
        cyc("p_reload",0, LOAD, 0, 4'd5, 0, 0, 0, 4'd5);
        cyc("p_r1",    0, RUN,  0, 4'd5, 0, 0, 0, 4'd4);
        cyc("p_r2",    0, RUN,  0, 4'd5, 0, 0, 0, 4'd3);
        cyc("p_r3",    0, RUN,  0, 4'd5, 0, 0, 0, 4'd2);
        cyc("p_r4",    0, RUN,  0, 4'd5, 0, 0, 0, 4'd1);
        cyc("p_r5",    0, RUN,  0, 4'd5, 0, 1, 0, 4'd0);
        cyc("p_ack",   0, CLEAR,0, 4'd5, 0, 0, 0, 4'd0);

        // Zero length: LOAD goes straight to DONE; RUN in DONE holds at 0
        cyc("z_start", 0, HOLD, 1, 4'd0, 1, 0, 0, 4'd0);
        cyc("z_load",  0, LOAD, 0, 4'd0, 0, 1, 0, 4'd0);
        cyc("z_run",   0, RUN,  0, 4'd0, 0, 1, 0, 4'd0);
        cyc("z_hold",  0, HOLD, 0, 4'd0, 0, 1, 0, 4'd0);
        cyc("z_ack",   0, CLEAR,0, 4'd0, 0, 0, 0, 4'd0);

        // Abort from RUN, then a normal length-2 run
        cyc("a_start", 0, HOLD, 1, 4'd7, 1, 0, 0, 4'd0);
        cyc("a_load",  0, LOAD, 0, 4'd7, 0, 0, 0, 4'd7);
        cyc("a_run1",  0, RUN,  0, 4'd7, 0, 0, 0, 4'd6);
        cyc("a_run2",  0, RUN,  0, 4'd7, 0, 0, 0, 4'd5);
        cyc("a_abort", 0, CLEAR,0, 4'd7, 0, 0, 1, 4'd0);
        cyc("a_clr",   0, HOLD, 0, 4'd7, 0, 0, 0, 4'd0);
        cyc("a2_start",0, HOLD, 1, 4'd2, 1, 0, 0, 4'd0);
        cyc("a2_load", 0, LOAD, 0, 4'd2, 0, 0, 0, 4'd2);
        cyc("a2_run1", 0, RUN,  0, 4'd2, 0, 0, 0, 4'd1);
        cyc("a2_run2", 0, RUN,  0, 4'd2, 0, 1, 0, 4'd0);
        cyc("a2_ack",  0, CLEAR,0, 4'd2, 0, 0, 0, 4'd0);

        // Start with CLEAR in IDLE: start wins; then abort from ARMED
        cyc("sc_start",0, CLEAR,1, 4'd4, 1, 0, 0, 4'd0);
        cyc("sc_hold", 0, RUN,  0, 4'd4, 1, 0, 0, 4'd0);
        cyc("sc_abort",0, CLEAR,0, 4'd4, 0, 0, 1, 4'd0);
        cyc("sc_clr",  0, CLEAR,0, 4'd4, 0, 0, 0, 4'd0);

        // Length 15: late inputLen change, ignored start in RUN, reset mid-run
        cyc("r_start", 0, HOLD, 1, 4'd15, 1, 0, 0, 4'd0);
        cyc("r_load",  0, LOAD, 0, 4'd3,  0, 0, 0, 4'd15);
        cyc("r_run1",  0, RUN,  0, 4'd3,  0, 0, 0, 4'd14);
        cyc("r_run2",  0, RUN,  0, 4'd3,  0, 0, 0, 4'd13);
        cyc("r_run3",  0, RUN,  1, 4'd2,  0, 0, 0, 4'd12);
        cyc("r_run4",  0, RUN,  0, 4'd2,  0, 0, 0, 4'd11);
        cyc("r_reload",0, LOAD, 0, 4'd2,  0, 0, 0, 4'd15);
        for (int k = 0; k < 6; k++)
            cyc("r_run", 0, RUN, 0, 4'd2, 0, 0, 0, 4'(14 - k));
        cyc("r_reset", 1, RUN,  0, 4'd2,  0, 0, 0, 4'd0);
        cyc("r_post",  0, RUN,  0, 4'd2,  0, 0, 0, 4'd0);

        // Length 1 after reset: single RUN edge reaches DONE
        cyc("o_start", 0, HOLD, 1, 4'd1, 1, 0, 0, 4'd0);
        cyc("o_load",  0, LOAD, 0, 4'd1, 0, 0, 0, 4'd1);
        cyc("o_run",   0, RUN,  0, 4'd1, 0, 1, 0, 4'd0);
        cyc("o_ack",   0, CLEAR,0, 4'd1, 0, 0, 0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
